// File: rtl/icache_refill_ctrl.sv
// Direct-mapped read-only instruction cache with a single-burst refill engine.
// Lookups are combinational against flop-based tag/valid/data storage; a miss
// stalls fetch while one incrementing burst fills the line through a buffer.
module icache_refill_ctrl #(
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_en,
    input  logic [31:0] inst_addr,
    input  logic        flush,
    output logic [31:0] inst_rdata,
    output logic        stall,
    output logic [31:0] i_araddr,
    output logic [7:0]  i_arlen,
    output logic        i_arvalid,
    input  logic        i_arready,
    input  logic [31:0] i_rdata,
    input  logic        i_rlast,
    input  logic        i_rvalid,
    output logic        i_rready
);

    localparam int LINES  = 1 << INDEX_WIDTH;
    localparam int WORD_W = OFFSET_WIDTH - 2;
    localparam int WORDS  = 1 << WORD_W;
    localparam int TAG_W  = 32 - INDEX_WIDTH - OFFSET_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [LINES-1:0]        valid;
    logic [TAG_W-1:0]        tag_ram  [LINES];
    logic [31:0]             data_ram [LINES][WORDS];
    logic [31:0]             line_buf [WORDS];
    logic [WORD_W-1:0]       beat_cnt;
    logic [31:0]             miss_addr;

    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_WIDTH-1:0]  req_index;
    logic [WORD_W-1:0]       req_word;
    logic [TAG_W-1:0]        miss_tag;
    logic [INDEX_WIDTH-1:0]  miss_index;
    logic                    hit;
    logic                    beat_fire;
    logic                    install;
    logic                    addr_unused;

    assign req_tag    = inst_addr[31:INDEX_WIDTH+OFFSET_WIDTH];
    assign req_index  = inst_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
    assign req_word   = inst_addr[OFFSET_WIDTH-1:2];
    assign miss_tag   = miss_addr[31:INDEX_WIDTH+OFFSET_WIDTH];
    assign miss_index = miss_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
    // Byte lane bits are irrelevant for word-wide instruction fetch.
    assign addr_unused = ^inst_addr[1:0];

    assign hit        = valid[req_index] & (tag_ram[req_index] == req_tag);
    assign inst_rdata = hit ? data_ram[req_index][req_word] : 32'b0;
    assign stall      = inst_en & ~hit;

    assign beat_fire  = (state == R) & i_rvalid;
    assign install    = beat_fire & i_rlast;

    assign i_araddr   = miss_addr;
    assign i_arlen    = 8'(WORDS - 1);

    // Refill state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Refill sequencing: miss -> address handshake -> beats until rlast.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (inst_en && !hit) state_next = AR;
            AR:      if (i_arready)       state_next = R;
            R:       if (install)         state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus handshake outputs decoded from the refill state.
    always_comb begin
        i_arvalid = 1'b0;
        i_rready  = 1'b0;
        case (state)
            AR:      i_arvalid = 1'b1;
            R:       i_rready  = 1'b1;
            default: ;
        endcase
    end

    // Miss address capture, beat counter and valid bits; an install overrides
    // a same-cycle flush for its own line because it is assigned last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_addr <= 32'b0;
            beat_cnt  <= '0;
            valid     <= '0;
        end else begin
            if (state == IDLE && inst_en && !hit) begin
                miss_addr <= {inst_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
            end
            if (install) begin
                beat_cnt <= '0;
            end else if (beat_fire) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (flush) begin
                valid <= '0;
            end
            if (install) begin
                valid[miss_index] <= 1'b1;
            end
        end
    end

    // Line buffer collects beats; on rlast the buffer (with the final beat
    // merged in) and the tag are written into the missing line.
    always_ff @(posedge clk) begin
        if (beat_fire) begin
            line_buf[beat_cnt] <= i_rdata;
        end
        if (install) begin
            tag_ram[miss_index] <= miss_tag;
            for (int w = 0; w < WORDS; w++) begin
                data_ram[miss_index][w] <= (WORD_W'(w) == beat_cnt) ? i_rdata : line_buf[w];
            end
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboarded bench for icache_refill_ctrl: a cache model predicts hit/miss
// and fetched data, a responder plays the arbiter, a monitor checks fetches.
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_en = 1'b0;
    logic [31:0] inst_addr = 32'b0;
    logic        flush = 1'b0;
    logic [31:0] inst_rdata;
    logic        stall;
    logic [31:0] i_araddr;
    logic [7:0]  i_arlen;
    logic        i_arvalid;
    logic        i_arready = 1'b0;
    logic [31:0] i_rdata = 32'b0;
    logic        i_rlast = 1'b0;
    logic        i_rvalid = 1'b0;
    logic        i_rready;

    icache_refill_ctrl dut (
        .clk(clk), .rst(rst), .inst_en(inst_en), .inst_addr(inst_addr),
        .flush(flush), .inst_rdata(inst_rdata), .stall(stall),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid),
        .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast),
        .i_rvalid(i_rvalid), .i_rready(i_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        int          mode;   // 0 full burst, 1 interrupted by reset, 2 early rlast
    } ar_t;

    logic        ref_valid [64];
    logic [20:0] ref_tag   [64];
    logic [31:0] ref_data  [64][8];
    logic [31:0] ref_buf   [8];
    logic [31:0] exp_q[$];
    ar_t         ar_q[$];

    int next_ar_delay  = -1;
    int last_rlast_cyc = 0;
    int bursts_done    = 0;
    bit resp_paused    = 1'b0;
    bit resp_go        = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:5] == 27'h5FE0000) return 32'h1000 + 32'(a[4:2]);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Cache model: decide hit/miss, and on a miss install the line the burst will deliver.
    task automatic predict(input logic [31:0] a, input int mode, output logic [31:0] e, output bit h);
        int          idx = int'(a[10:5]);
        logic [20:0] tg  = a[31:11];
        int          w   = int'(a[4:2]);
        int          n;
        ar_t         t;
        h = ref_valid[idx] && (ref_tag[idx] == tg);
        if (!h) begin
            t.addr = {a[31:5], 5'b0};
            t.mode = mode;
            ar_q.push_back(t);
            n = (mode == 2) ? 5 : 8;
            for (int i = 0; i < n; i++) ref_buf[i] = mem_word(t.addr + 32'(4 * i));
            for (int i = 0; i < 8; i++) ref_data[idx][i] = ref_buf[i];
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end
        e = ref_data[idx][w];
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic wait_rready(input string name);
        int k = 0;
        while (!i_rready && k < 300) begin @(posedge clk); #1; k++; end
        chk1(name, i_rready, 1'b1);
    endtask

    task automatic fetch(input logic [31:0] a, input int mode, input bit flush_in_r);
        logic [31:0] e;
        bit          h;
        int          n = 0;
        predict(a, mode, e, h);
        exp_q.push_back(e);
        inst_addr = a;
        inst_en   = 1'b1;
        @(negedge clk);
        chk1("stall_on_request", stall, !h);
        if (flush_in_r) begin
            wait_rready("rready_before_flush");
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            clear_model();
            ref_valid[int'(a[10:5])] = 1'b1;
        end
        while (stall && n < 400) begin @(negedge clk); n++; end
        if (stall) begin
            chk1("fetch_timeout", stall, 1'b0);
            void'(exp_q.pop_back());
        end else if (!h) begin
            chk("refill_latency", cyc, last_rlast_cyc);
        end
        @(posedge clk); #1;
        inst_en = 1'b0;
    endtask

    // Start a miss without queuing a fetch result; returns once in the data phase.
    task automatic start_miss(input logic [31:0] a);
        logic [31:0] e;
        bit          h;
        predict(a, 0, e, h);
        inst_addr = a;
        inst_en   = 1'b1;
        @(negedge clk);
        chk1("stall_start_miss", stall, 1'b1);
        @(posedge clk); #1;
        wait_rready("rready_start_miss");
    endtask

    task automatic wait_burst(input int n0);
        int k = 0;
        while (bursts_done == n0 && k < 400) begin @(posedge clk); #2; k++; end
        chk("burst_completed", bursts_done, n0 + 1);
    endtask

    // Monitor: every accepted fetch pops one expected word.
    always @(negedge clk) begin
        if (!rst && inst_en && !stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch actual=%h required=no_output", inst_rdata);
            end else begin
                chk("fetch_data", inst_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic serve();
        ar_t         t;
        int          d;
        int          n;
        int          k;
        if (ar_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ar actual=%h required=no_request", i_araddr);
            t.addr = i_araddr;
            t.mode = 0;
        end else begin
            t = ar_q.pop_front();
            chk("araddr", i_araddr, t.addr);
        end
        chk("arlen", {24'b0, i_arlen}, 32'd7);
        d = (next_ar_delay >= 0) ? next_ar_delay : int'($urandom_range(0, 3));
        next_ar_delay = -1;
        repeat (d) begin
            @(posedge clk); #1;
            chk1("arvalid_hold", i_arvalid, 1'b1);
            chk("araddr_hold", i_araddr, t.addr);
        end
        i_arready = 1'b1;
        @(posedge clk); #1;
        i_arready = 1'b0;
        chk1("arvalid_drop", i_arvalid, 1'b0);
        n = (t.mode == 2) ? 5 : ((t.mode == 1) ? 3 : 8);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            chk1("rready", i_rready, 1'b1);
            i_rvalid = 1'b1;
            i_rdata  = mem_word(t.addr + 32'(4 * i));
            i_rlast  = (t.mode != 1) && (i == n - 1);
            @(posedge clk); #1;
            i_rvalid = 1'b0;
            i_rlast  = 1'b0;
        end
        if (t.mode == 1) begin
            resp_paused = 1'b1;
            k = 0;
            while (!resp_go && k < 200) begin @(posedge clk); #1; k++; end
            chk1("resp_go_seen", resp_go, 1'b1);
            resp_paused = 1'b0;
            for (int i = 3; i < 8; i++) begin
                chk1("rready_after_reset", i_rready, 1'b0);
                i_rvalid = 1'b1;
                i_rdata  = 32'hBAD0_0000 + 32'(i);
                i_rlast  = (i == 7);
                @(posedge clk); #1;
            end
            i_rvalid = 1'b0;
            i_rlast  = 1'b0;
        end else begin
            last_rlast_cyc = cyc;
            bursts_done++;
        end
    endtask

    // Arbiter responder.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst || !i_arvalid) continue;
            serve();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        logic [31:0] a;
        int          n0;
        clear_model();
        inst_en   = 1'b1;
        inst_addr = 32'hBFC0_0004;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_arvalid", i_arvalid, 1'b0);
        chk1("rst_rready", i_rready, 1'b0);
        chk("rst_araddr", i_araddr, 32'h0);
        chk("rst_rdata", inst_rdata, 32'h0);
        chk1("rst_stall", stall, 1'b1);
        inst_en = 1'b0;
        rst     = 1'b0;
        @(posedge clk); #1;

        // Cold miss with a held-off address handshake, then hits across the line.
        next_ar_delay = 3;
        fetch(32'hBFC0_0004, 0, 1'b0);
        for (int i = 0; i < 8; i++) fetch(32'hBFC0_0000 + 32'(4 * i), 0, 1'b0);

        // Conflict miss on the same index, then the original line misses again.
        fetch(32'hBFC0_0800, 0, 1'b0);
        fetch(32'hBFC0_0000, 0, 1'b0);

        // Flush while idle.
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        clear_model();
        fetch(32'hBFC0_0008, 0, 1'b0);

        // Flush during a refill keeps the refilled line only.
        fetch(32'h0000_1040, 0, 1'b0);
        fetch(32'hBFC0_0020, 0, 1'b1);
        fetch(32'hBFC0_0024, 0, 1'b0);
        fetch(32'h0000_1044, 0, 1'b0);

        // Early rlast: unreceived words keep the previous buffer contents.
        fetch(32'h0000_2018, 2, 1'b0);
        fetch(32'h0000_2008, 0, 1'b0);
        fetch(32'h0000_201C, 0, 1'b0);

        // Fetch abandoned mid-refill still installs the line.
        n0 = bursts_done;
        start_miss(32'h0000_3000);
        inst_en = 1'b0;
        wait_burst(n0);
        fetch(32'h0000_3004, 0, 1'b0);

        // Address moves to a hitting line mid-refill; the missed line is installed.
        n0 = bursts_done;
        start_miss(32'h0000_4020);
        fetch(32'h0000_3008, 0, 1'b0);
        wait_burst(n0);
        fetch(32'h0000_4024, 0, 1'b0);

        // Reset after three beats of a burst.
        begin
            ar_t t;
            int  k = 0;
            t.addr = 32'hBFC0_0000;
            t.mode = 1;
            ar_q.push_back(t);
            for (int i = 0; i < 3; i++) ref_buf[i] = mem_word(32'hBFC0_0000 + 32'(4 * i));
            inst_addr = 32'hBFC0_0004;
            inst_en   = 1'b1;
            while (!resp_paused && k < 300) begin @(posedge clk); #2; k++; end
            chk1("partial_burst_paused", resp_paused, 1'b1);
            chk1("rready_before_reset", i_rready, 1'b1);
            rst = 1'b1;
            #1;
            chk1("midrst_rready", i_rready, 1'b0);
            chk1("midrst_arvalid", i_arvalid, 1'b0);
            chk("midrst_araddr", i_araddr, 32'h0);
            chk("midrst_rdata", inst_rdata, 32'h0);
            chk1("midrst_stall", stall, 1'b1);
            @(posedge clk);
            @(posedge clk); #1;
            rst = 1'b0;
            clear_model();
            resp_go = 1'b1;
            fetch(32'hBFC0_0004, 0, 1'b0);
            resp_go = 1'b0;
            fetch(32'h0000_4024, 0, 1'b0);
        end

        // Randomized traffic over a few conflicting tags.
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                clear_model();
            end
            case ($urandom_range(0, 2))
                0:       base = 32'hBFC0_0000;
                1:       base = 32'h0001_0000;
                default: base = 32'h7FFF_0000;
            endcase
            a = base + 32'($urandom_range(0, 3) * 32) + 32'($urandom_range(0, 7) * 4);
            fetch(a, ($urandom_range(0, 7) == 0) ? 2 : 0, 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("ar_queue_drained", ar_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Direct-mapped, read-only instruction cache with its own refill state machine.
- Sits between the CPU fetch stage and the I-side read channel of the memory arbiter. It drives the arbiter's i_araddr/i_arlen/i_arvalid and i_rready, and consumes i_rdata/i_rlast/i_rvalid.
- Hits return data combinationally in the same cycle. Misses stall fetch while one incrementing burst refills the line.

Parameters:
- INDEX_WIDTH, 6, number of index bits; the cache has 2^INDEX_WIDTH lines.
- OFFSET_WIDTH, 5, byte-offset bits per line; a line holds 2^(OFFSET_WIDTH-2) 32-bit words (default 8).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- inst_en  input  1  fetch request valid.
- inst_addr  input  32  fetch byte address; bits [1:0] are ignored.
- flush  input  1  invalidate all lines.
- inst_rdata  output  32  fetched instruction; valid when inst_en=1 and stall=0.
- stall  output  1  fetch must hold inst_addr stable while this is high.
- i_araddr  output  32  refill burst address, line-aligned.
- i_arlen  output  8  burst length-1, constant 2^(OFFSET_WIDTH-2)-1.
- i_arvalid  output  1  read address valid.
- i_arready  input  1  address accepted by the arbiter.
- i_rdata  input  32  refill data beat.
- i_rlast  input  1  last beat of the burst.
- i_rvalid  input  1  beat valid.
- i_rready  output  1  beat accept.

Behaviour:
- Address split: tag = addr[31:INDEX_WIDTH+OFFSET_WIDTH], index = addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH], word = addr[OFFSET_WIDTH-1:2].
- Storage: per-line valid bit, tag register and word array, held in flops with asynchronous read.
- hit = valid[index] & (tag_ram[index] == tag).
- inst_rdata = data[index][word] when hit, else 32'b0.
- stall = inst_en & ~hit, computed combinationally in every state.
- FSM states:
  - IDLE: if inst_en & ~hit, latch miss_addr = {inst_addr[31:OFFSET_WIDTH], 0} and go to AR.
  - AR: i_arvalid=1, i_araddr=miss_addr. On i_arready go to R; i_arvalid falls the next cycle.
  - R: i_rready=1. Each beat with i_rvalid=1 writes i_rdata into a line buffer at beat_cnt, then beat_cnt increments (wraps at word count).
  - On the beat with i_rvalid & i_rlast: write the line buffer (including this beat) to data[miss index], write tag, set valid, clear beat_cnt, go to IDLE.
- Refill latency: the lookup hits in the cycle after the rlast beat, so stall falls one cycle after i_rlast.
- i_araddr holds miss_addr in every state; i_arlen is constant.
- AR handshake: i_arvalid stays asserted without dropping until i_arready. Only one outstanding burst at a time.
- Early i_rlast (fewer beats than the line size): the line is still installed; words not received keep their previous buffer contents.
- Beats arriving in IDLE or AR (i_rvalid with i_rready=0) are ignored.
- inst_en dropping mid-refill: the refill still completes and installs the line.
- inst_addr changing mid-refill: the installed line follows miss_addr, not the new address.
- flush:
  - Clears all valid bits in the same clock edge, in any state.
  - If a refill is in flight, that line is still installed and made valid on rlast, so the installed line survives a flush issued during its own refill.
  - flush and an install in the same cycle: the install wins for that line only.
- Reset, asserted at any time, including mid-burst:
  - State=IDLE, all valid bits=0, beat_cnt=0, miss_addr=0.
  - Outputs: i_arvalid=0, i_rready=0, i_araddr=0, inst_rdata=0.
  - stall follows inst_en, since every access misses.
  - Any remaining beats of an interrupted burst arriving after reset is released are ignored outside state R.

Test Plan:
- Cold miss: inst_en=1, addr 0xBFC00004 → stall=1, i_arvalid=1, i_araddr=0xBFC00000, i_arlen=7. Hold i_arready low 3 cycles → i_arvalid stays 1. Send 8 beats 0x1000..0x1007 → stall=0 one cycle after rlast, inst_rdata=0x1001.
- Hit after fill: addresses 0xBFC00000..0xBFC0001C → stall=0 each cycle, data 0x1000..0x1007, no i_arvalid.
- Conflict miss: 0xBFC00800 (same index, different tag) → new burst at 0xBFC00800. Afterwards 0xBFC00000 misses again.
- Backpressured data: i_rvalid toggles 1/0 across 8 beats → all 8 words stored correctly and beat_cnt ends at 0.
- Flush: after a fill, pulse flush → next access to 0xBFC00000 misses. Flush during R → the line is valid after rlast and a subsequent access hits.
- Reset during R after 3 beats → i_rready=0, state IDLE, all lines miss, trailing beats ignored; the next request issues a fresh burst.
